inbuf_sram_fifo: RTL and testbench

SRAM-backed synchronous FIFO that buffers host data words ahead of the input buffer controller. The host pushes INBUF_MEM_DATA_W-bit words on the write side. The control block pops them through the rd_rq / mem_en / empty interface, and each popped word is delivered to the engine one cycle later with a valid strobe. The block also reports level, almost-full, and sticky overflow/underflow errors to the control registers.

---
 rtl/inbuf_sram_fifo_pkg.sv | 10 +
 rtl/inbuf_sram_1r1w.sv | 39 +++
 rtl/inbuf_sram_fifo.sv | 117 +++++++++++
 tb/tb_inbuf_sram_fifo.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/inbuf_sram_fifo_pkg.sv
// Shared sizing for the host input buffer FIFO and its backing SRAM.
// Word width, address width, derived depth and the almost-full margin.
package inbuf_sram_fifo_pkg;

  localparam int INBUF_MEM_DATA_W = 64;
  localparam int INBUF_MEM_ADDR_W = 6;
  localparam int INBUF_FIFO_DEPTH = 1 << INBUF_MEM_ADDR_W;
  localparam int AF_MARGIN        = 4;

endpackage

// File: rtl/inbuf_sram_1r1w.sv
// Behavioural 1-read/1-write SRAM with a registered read port (1-cycle latency).
// Only the read register is reset; the array is not, so a compiled macro can replace it.
module inbuf_sram_1r1w
  import inbuf_sram_fifo_pkg::*;
#(
  parameter int DATA_W = INBUF_MEM_DATA_W,
  parameter int ADDR_W = INBUF_MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read register only updates on an enabled read, so the output holds between pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/inbuf_sram_fifo.sv
// SRAM-backed synchronous FIFO between the host write port and the input buffer controller.
// Wrap-bit pointers give empty/full/level; pops return data one cycle later with a valid pulse.
module inbuf_sram_fifo
  import inbuf_sram_fifo_pkg::*;
#(
  parameter int DATA_W   = INBUF_MEM_DATA_W,
  parameter int ADDR_W   = INBUF_MEM_ADDR_W,
  parameter int AF_LIMIT = AF_MARGIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              host_inbuf_wr_en,
  input  logic [DATA_W-1:0] host_inbuf_wr_data,
  output logic              inbuf_host_full,
  output logic              inbuf_host_almost_full,
  input  logic              cntl_inbuf_fifo_rd_rq,
  input  logic              cntl_inbuf_fifo_mem_en,
  output logic              inbuf_fifo_cntl_empty,
  output logic [DATA_W-1:0] inbuf_fifo_rd_data,
  output logic              inbuf_fifo_rd_data_val,
  output logic [ADDR_W:0]   inbuf_fifo_level,
  output logic              inbuf_fifo_ovf_err,
  output logic              inbuf_fifo_udf_err
);

  localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W + 1)'(AF_LIMIT);

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic            val_q, val_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;

  logic            full, empty, pop_req, push_ok, pop_ok;
  logic [ADDR_W:0] level, free_cnt;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                    (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign level    = wr_ptr_q - rd_ptr_q;
  assign free_cnt = DEPTH_CNT - level;

  // Accept decisions use start-of-cycle status; flush discards both sides.
  assign pop_req = cntl_inbuf_fifo_rd_rq && cntl_inbuf_fifo_mem_en;
  assign push_ok = host_inbuf_wr_en && !full && !flush;
  assign pop_ok  = pop_req && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    val_d    = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        val_d    = 1'b1;
      end
      if (host_inbuf_wr_en && full) begin
        ovf_d = 1'b1;
      end
      if (pop_req && empty) begin
        udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      val_q    <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      val_q    <= val_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  inbuf_sram_1r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_sram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_data (host_inbuf_wr_data),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr_q[ADDR_W-1:0]),
    .rd_data (inbuf_fifo_rd_data)
  );

  assign inbuf_host_full        = full;
  assign inbuf_host_almost_full = (free_cnt <= AF_CNT);
  assign inbuf_fifo_cntl_empty  = empty;
  assign inbuf_fifo_rd_data_val = val_q;
  assign inbuf_fifo_level       = level;
  assign inbuf_fifo_ovf_err     = ovf_q;
  assign inbuf_fifo_udf_err     = udf_q;

endmodule

// File: tb/tb_inbuf_sram_fifo.sv
// Directed bench for inbuf_sram_fifo: a queue model of the FIFO feeds a scoreboard of
// expected read words; every cycle all status outputs and the read port are checked.
module tb_inbuf_sram_fifo;
  import inbuf_sram_fifo_pkg::*;

  localparam int DW    = INBUF_MEM_DATA_W;
  localparam int AW    = INBUF_MEM_ADDR_W;
  localparam int DEPTH = INBUF_FIFO_DEPTH;

  logic          clk = 1'b0;
  logic          rst, flush, wr, rq, en;
  logic [DW-1:0] wdata;
  logic          full, afull, empty, rd_val, ovf, udf;
  logic [DW-1:0] rd_data;
  logic [AW:0]   level;

  always #5 clk = ~clk;

  inbuf_sram_fifo dut (
    .clk                    (clk),
    .rst                    (rst),
    .flush                  (flush),
    .host_inbuf_wr_en       (wr),
    .host_inbuf_wr_data     (wdata),
    .inbuf_host_full        (full),
    .inbuf_host_almost_full (afull),
    .cntl_inbuf_fifo_rd_rq  (rq),
    .cntl_inbuf_fifo_mem_en (en),
    .inbuf_fifo_cntl_empty  (empty),
    .inbuf_fifo_rd_data     (rd_data),
    .inbuf_fifo_rd_data_val (rd_val),
    .inbuf_fifo_level       (level),
    .inbuf_fifo_ovf_err     (ovf),
    .inbuf_fifo_udf_err     (udf)
  );

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] sb[$];
  logic          exp_val = 1'b0;
  logic          exp_ovf = 1'b0;
  logic          exp_udf = 1'b0;
  logic [DW-1:0] last_data = '0;
  logic [DW-1:0] word_ctr = 64'h1000;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock: update the model from start-of-cycle state, then compare.
  task automatic cycle();
    bit            full_m, empty_m;
    int            lvl;
    logic [DW-1:0] d;
    full_m  = (mq.size() == DEPTH);
    empty_m = (mq.size() == 0);
    if (rst) begin
      mq.delete(); sb.delete();
      exp_val = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0; last_data = '0;
    end else if (flush) begin
      mq.delete(); sb.delete();
      exp_val = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
    end else begin
      exp_val = rq && en && !empty_m;
      if (wr && full_m) exp_ovf = 1'b1;
      if (rq && en && empty_m) exp_udf = 1'b1;
      if (exp_val) sb.push_back(mq.pop_front());
      if (wr && !full_m) mq.push_back(wdata);
    end
    @(posedge clk);
    #1;
    lvl = mq.size();
    chk("rd_data_val", DW'(rd_val), DW'(exp_val));
    if (exp_val && sb.size() > 0) begin
      d = sb.pop_front();
      chk("rd_data", rd_data, d);
      last_data = d;
    end else begin
      chk("rd_data_hold", rd_data, last_data);
    end
    chk("level", DW'(level), DW'(lvl));
    chk("empty", DW'(empty), DW'(lvl == 0));
    chk("full", DW'(full), DW'(lvl == DEPTH));
    chk("almost_full", DW'(afull), DW'((DEPTH - lvl) <= AF_MARGIN));
    chk("ovf_err", DW'(ovf), DW'(exp_ovf));
    chk("udf_err", DW'(udf), DW'(exp_udf));
    $display("t=%0t wr=%0b rq=%0b en=%0b fl=%0b rst=%0b lvl=%0d val=%0b data=%0h",
             $time, wr, rq, en, flush, rst, level, rd_val, rd_data);
  endtask

  task automatic set_in(input logic w, input logic [DW-1:0] d, input logic r, input logic e);
    wr = w; wdata = d; rq = r; en = e;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    set_in(1'b1, d, 1'b0, 1'b0); cycle(); set_in(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic pop_word();
    set_in(1'b0, '0, 1'b1, 1'b1); cycle(); set_in(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic push_pop(input logic [DW-1:0] d);
    set_in(1'b1, d, 1'b1, 1'b1); cycle(); set_in(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic next_word(output logic [DW-1:0] d);
    word_ctr = word_ctr + 64'd1;
    d = {$urandom(), word_ctr[31:0]};
  endtask

  initial begin
    logic [DW-1:0] w;
    rst = 1'b1; flush = 1'b0;
    set_in(1'b0, '0, 1'b0, 1'b0);
    cycle(); cycle();
    rst = 1'b0;
    cycle();

    // Four words in, four back-to-back pops out.
    for (int i = 0; i < 4; i++) push_word(DW'(8'h11 + i));
    for (int i = 0; i < 4; i++) pop_word();
    cycle();

    // Fill to full, overflow once, then drain everything.
    for (int i = 0; i < DEPTH; i++) begin next_word(w); push_word(w); end
    next_word(w); push_word(w);
    cycle();
    for (int i = 0; i < DEPTH; i++) pop_word();
    cycle();

    // Underflow, then a gated pop on a non-empty FIFO.
    pop_word();
    rst = 1'b1; cycle(); rst = 1'b0;
    next_word(w); push_word(w);
    set_in(1'b0, '0, 1'b1, 1'b0); cycle(); set_in(1'b0, '0, 1'b0, 1'b0);
    pop_word();
    cycle();

    // 200 pushes / 200 pops around a low level, wrapping the pointers.
    for (int i = 0; i < 3; i++) begin next_word(w); push_word(w); end
    for (int k = 0; k < 197; k++) begin
      next_word(w);
      if (k % 5 == 0) begin push_word(w); pop_word(); end
      else push_pop(w);
    end
    for (int i = 0; i < 3; i++) pop_word();
    cycle();

    // Simultaneous push/pop at full, then at empty.
    for (int i = 0; i < DEPTH; i++) begin next_word(w); push_word(w); end
    next_word(w); push_pop(w);
    cycle();
    for (int i = 0; i < DEPTH - 1; i++) pop_word();
    cycle();
    next_word(w); push_pop(w);
    cycle();
    pop_word();
    cycle();

    // Flush right after a pop at level 10, with push and pop also requested.
    for (int i = 0; i < 11; i++) begin next_word(w); push_word(w); end
    pop_word();
    next_word(w);
    set_in(1'b1, w, 1'b1, 1'b1); flush = 1'b1; cycle();
    flush = 1'b0; set_in(1'b0, '0, 1'b0, 1'b0);
    next_word(w); push_word(w); pop_word(); cycle();

    // Reset mid-stream behaves the same way.
    for (int i = 0; i < 7; i++) begin next_word(w); push_word(w); end
    pop_word();
    rst = 1'b1; cycle(); rst = 1'b0;
    next_word(w); push_word(w); pop_word(); cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
